// File: rtl/transpose_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// transpose_buffer_ctrl
//
// Ping/pong controller for a transpose buffer. Rows of FETCH_WIDTH words arrive
// from memory and are written row by row into one half of the buffer. When a
// half holds NUM_ROWS rows, or is closed early by flush, it becomes readable.
// It is then drained column by column, FETCH_WIDTH columns in total, while the
// other half fills.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   row_valid   : memory presents one row this cycle
//   valid_input : per-word valid mask of the presented row
//   row_ready   : controller accepts a row this cycle
//   flush       : close the partially filled write half
//   wr_en       : buffer write strobe (row_valid & row_ready)
//   wr_buf      : half being written
//   wr_row      : row index being written
//   rd_valid    : a column is available to read
//   rd_ready    : downstream consumes the column
//   rd_buf      : half being read
//   rd_col      : column index being read
//   rd_rows     : rows held in half rd_buf
//   rd_words    : valid words held in half rd_buf
// -----------------------------------------------------------------------------
module transpose_buffer_ctrl #(
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_ROWS    = 4,
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CNT_W  = $clog2(NUM_ROWS) + 1,
  localparam int WORD_W = $clog2(FETCH_WIDTH * NUM_ROWS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   row_valid,
  input  logic [FETCH_WIDTH-1:0] valid_input,
  output logic                   row_ready,
  input  logic                   flush,
  output logic                   wr_en,
  output logic                   wr_buf,
  output logic [ROW_W-1:0]       wr_row,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_buf,
  output logic [COL_W-1:0]       rd_col,
  output logic [CNT_W-1:0]       rd_rows,
  output logic [WORD_W-1:0]      rd_words
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FETCH_WIDTH - 1);

  // Number of set bits in the word-valid mask, already at the word-count width
  function automatic logic [WORD_W-1:0] popcount(input logic [FETCH_WIDTH-1:0] mask);
    logic [WORD_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      cnt = cnt + WORD_W'(mask[i]);
    end
    return cnt;
  endfunction

  // Registered state
  logic [1:0]        r_full;
  logic              r_wr_buf;
  logic [ROW_W-1:0]  r_wr_row;
  logic              r_rd_buf;
  logic [COL_W-1:0]  r_rd_col;
  logic [CNT_W-1:0]  r_rows  [2];
  logic [WORD_W-1:0] r_words [2];

  // Next-state values
  logic [1:0]        w_full_nxt;
  logic              w_wr_buf_nxt;
  logic [ROW_W-1:0]  w_wr_row_nxt;
  logic              w_rd_buf_nxt;
  logic [COL_W-1:0]  w_rd_col_nxt;
  logic [CNT_W-1:0]  w_rows_nxt  [2];
  logic [WORD_W-1:0] w_words_nxt [2];

  // Handshake decode
  logic w_row_fire;
  logic w_close;
  logic w_rd_fire;
  logic w_rd_done;

  assign w_row_fire = row_valid & ~r_full[r_wr_buf];
  // A half closes when its last row lands, or on flush if it holds (or is
  // receiving this cycle) at least one row; flushing an empty half is ignored.
  assign w_close    = (w_row_fire & (r_wr_row == LAST_ROW)) |
                      (flush & (w_row_fire | (r_wr_row != '0)));
  assign w_rd_fire  = r_full[r_rd_buf] & rd_ready;
  assign w_rd_done  = w_rd_fire & (r_rd_col == LAST_COL);

  // Outputs are pure views of the registered state (plus the row handshake)
  assign row_ready = ~r_full[r_wr_buf];
  assign wr_en     = w_row_fire;
  assign wr_buf    = r_wr_buf;
  assign wr_row    = r_wr_row;
  assign rd_valid  = r_full[r_rd_buf];
  assign rd_buf    = r_rd_buf;
  assign rd_col    = r_rd_col;
  assign rd_rows   = r_rows[r_rd_buf];
  assign rd_words  = r_words[r_rd_buf];

  // Next-state logic. The write half is never full and the read half is
  // always full while being read, so a close and a drain completing in the
  // same cycle always touch different halves and both apply.
  always_comb begin
    w_full_nxt   = r_full;
    w_wr_buf_nxt = r_wr_buf;
    w_wr_row_nxt = r_wr_row;
    w_rd_buf_nxt = r_rd_buf;
    w_rd_col_nxt = r_rd_col;
    w_rows_nxt   = r_rows;
    w_words_nxt  = r_words;

    // Write side: count the row first, then decide whether the half closes
    if (w_row_fire) begin
      w_rows_nxt[r_wr_buf]  = r_rows[r_wr_buf] + 1'b1;
      w_words_nxt[r_wr_buf] = r_words[r_wr_buf] + popcount(valid_input);
    end

    if (w_close) begin
      w_full_nxt[r_wr_buf] = 1'b1;
      w_wr_buf_nxt         = ~r_wr_buf;
      w_wr_row_nxt         = '0;
    end else if (w_row_fire) begin
      w_wr_row_nxt = r_wr_row + 1'b1;
    end

    // Read side: every column is drained, even for a partially filled half
    if (w_rd_fire) begin
      if (w_rd_done) begin
        w_full_nxt[r_rd_buf]  = 1'b0;
        w_rows_nxt[r_rd_buf]  = '0;
        w_words_nxt[r_rd_buf] = '0;
        w_rd_buf_nxt          = ~r_rd_buf;
        w_rd_col_nxt          = '0;
      end else begin
        w_rd_col_nxt = r_rd_col + 1'b1;
      end
    end
  end

  // State register; reset discards every buffered half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_wr_buf   <= 1'b0;
      r_wr_row   <= '0;
      r_rd_buf   <= 1'b0;
      r_rd_col   <= '0;
      r_rows[0]  <= '0;
      r_rows[1]  <= '0;
      r_words[0] <= '0;
      r_words[1] <= '0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_buf   <= w_wr_buf_nxt;
      r_wr_row   <= w_wr_row_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_rd_col   <= w_rd_col_nxt;
      r_rows     <= w_rows_nxt;
      r_words    <= w_words_nxt;
    end
  end

endmodule

// File: tb/tb_transpose_buffer_ctrl.sv
module tb_transpose_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       row_valid;
  logic [3:0] valid_input;
  logic       row_ready;
  logic       flush;
  logic       wr_en;
  logic       wr_buf;
  logic [1:0] wr_row;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_buf;
  logic [1:0] rd_col;
  logic [2:0] rd_rows;
  logic [4:0] rd_words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transpose_buffer_ctrl #(.FETCH_WIDTH(4), .NUM_ROWS(4)) dut (
    .clk(clk), .rst_n(rst_n), .row_valid(row_valid), .valid_input(valid_input),
    .row_ready(row_ready), .flush(flush), .wr_en(wr_en), .wr_buf(wr_buf),
    .wr_row(wr_row), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_buf(rd_buf),
    .rd_col(rd_col), .rd_rows(rd_rows), .rd_words(rd_words)
  );

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; row_valid = 1'b0; valid_input = 4'b0000; flush = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL reset_row_ready: got %0b want 1", row_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    checks++; if ({wr_buf, wr_row, rd_buf, rd_col} !== 6'd0) begin errors++; $display("FAIL reset_ptrs: got %0h want 0", {wr_buf, wr_row, rd_buf, rd_col}); end
    checks++; if ({rd_rows, rd_words} !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0h want 0", {rd_rows, rd_words}); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    rd_ready = 1'b1; row_valid = 1'b1; valid_input = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (wr_en !== 1'b1 || wr_row !== 2'(i)) begin errors++; $display("FAIL fill_wr row%0d: got en=%0b row=%0d want en=1 row=%0d", i, wr_en, wr_row, i); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_latency row%0d: got rd_valid=%0b want 0", i, rd_valid); end
      step();
    end
    row_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_buf !== 1'b0) begin errors++; $display("FAIL fill_rd_valid: got v=%0b buf=%0b want v=1 buf=0", rd_valid, rd_buf); end
    checks++; if (rd_rows !== 3'd4 || rd_words !== 5'd16) begin errors++; $display("FAIL fill_counts: got rows=%0d words=%0d want 4 16", rd_rows, rd_words); end
    checks++; if (wr_buf !== 1'b1 || wr_row !== 2'd0 || row_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_side: got buf=%0b row=%0d rdy=%0b want 1 0 1", wr_buf, wr_row, row_ready); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (rd_col !== 2'(c) || rd_valid !== 1'b1) begin errors++; $display("FAIL drain_col%0d: got col=%0d v=%0b want col=%0d v=1", c, rd_col, rd_valid, c); end
      step();
    end
    checks++; if (rd_buf !== 1'b1 || rd_valid !== 1'b0 || rd_col !== 2'd0) begin errors++; $display("FAIL drain_done: got buf=%0b v=%0b col=%0d want 1 0 0", rd_buf, rd_valid, rd_col); end
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    row_valid = 1'b1; valid_input = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    checks++; if (row_ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL b2b_stall: got rdy=%0b en=%0b want 0 0", row_ready, wr_en); end
    checks++; if (rd_valid !== 1'b1 || rd_buf !== 1'b0 || wr_buf !== 1'b0) begin errors++; $display("FAIL b2b_full: got v=%0b rbuf=%0b wbuf=%0b want 1 0 0", rd_valid, rd_buf, wr_buf); end
    row_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL b2b_early_ready: got %0b want 0", row_ready); end
    step();
    checks++; if (row_ready !== 1'b1 || wr_buf !== 1'b0) begin errors++; $display("FAIL b2b_reopen: got rdy=%0b wbuf=%0b want 1 0", row_ready, wr_buf); end
    checks++; if (rd_valid !== 1'b1 || rd_buf !== 1'b1 || rd_rows !== 3'd4) begin errors++; $display("FAIL b2b_second_half: got v=%0b buf=%0b rows=%0d want 1 1 4", rd_valid, rd_buf, rd_rows); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (rd_valid !== 1'b0 || rd_buf !== 1'b0) begin errors++; $display("FAIL b2b_all_drained: got v=%0b buf=%0b want 0 0", rd_valid, rd_buf); end
    rd_ready = 1'b0;
  endtask

  task automatic test_flush_partial();
    do_reset();
    row_valid = 1'b1; valid_input = 4'b0101; step();
    valid_input = 4'b0111; step();
    row_valid = 1'b0; valid_input = 4'b0000; flush = 1'b1; step();
    flush = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_rows !== 3'd2 || rd_words !== 5'd5) begin errors++; $display("FAIL flush_counts: got v=%0b rows=%0d words=%0d want 1 2 5", rd_valid, rd_rows, rd_words); end
    checks++; if (wr_buf !== 1'b1 || wr_row !== 2'd0) begin errors++; $display("FAIL flush_wr_side: got buf=%0b row=%0d want 1 0", wr_buf, wr_row); end
    rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rd_valid !== 1'b1 || rd_col !== 2'(c)) begin errors++; $display("FAIL flush_col%0d: got v=%0b col=%0d want 1 %0d", c, rd_valid, rd_col, c); end
      step();
    end
    checks++; if (rd_valid !== 1'b0 || rd_buf !== 1'b1) begin errors++; $display("FAIL flush_drained: got v=%0b buf=%0b want 0 1", rd_valid, rd_buf); end
    rd_ready = 1'b0;
  endtask

  task automatic test_flush_edges();
    do_reset();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (wr_buf !== 1'b0 || wr_row !== 2'd0 || rd_valid !== 1'b0 || row_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got wbuf=%0b row=%0d v=%0b rdy=%0b want 0 0 0 1", wr_buf, wr_row, rd_valid, row_ready); end
    row_valid = 1'b1; valid_input = 4'b1111; step(); step();
    valid_input = 4'b0001; flush = 1'b1; #1;
    checks++; if (wr_en !== 1'b1 || wr_row !== 2'd2) begin errors++; $display("FAIL flush_coinc_wr: got en=%0b row=%0d want 1 2", wr_en, wr_row); end
    step(); row_valid = 1'b0; flush = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_rows !== 3'd3 || rd_words !== 5'd9) begin errors++; $display("FAIL flush_coinc: got v=%0b rows=%0d words=%0d want 1 3 9", rd_valid, rd_rows, rd_words); end
    checks++; if (wr_buf !== 1'b1 || wr_row !== 2'd0) begin errors++; $display("FAIL flush_coinc_wr_side: got buf=%0b row=%0d want 1 0", wr_buf, wr_row); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    row_valid = 1'b1; valid_input = 4'b0011;
    for (int i = 0; i < 7; i++) step();
    row_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    row_valid = 1'b1; step();
    row_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_buf !== 1'b1 || rd_rows !== 3'd4 || rd_words !== 5'd8) begin errors++; $display("FAIL simul_read: got v=%0b buf=%0b rows=%0d words=%0d want 1 1 4 8", rd_valid, rd_buf, rd_rows, rd_words); end
    checks++; if (row_ready !== 1'b1 || wr_buf !== 1'b0 || wr_row !== 2'd0) begin errors++; $display("FAIL simul_write: got rdy=%0b buf=%0b row=%0d want 1 0 0", row_ready, wr_buf, wr_row); end
  endtask

  task automatic test_stall();
    do_reset();
    row_valid = 1'b1; valid_input = 4'b1010;
    for (int i = 0; i < 4; i++) step();
    row_valid = 1'b0; rd_ready = 1'b1; step(); step();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rd_valid !== 1'b1 || rd_buf !== 1'b0 || rd_col !== 2'd2 || rd_rows !== 3'd4 || rd_words !== 5'd8) begin
        errors++; $display("FAIL stall_cyc%0d: got v=%0b buf=%0b col=%0d rows=%0d words=%0d want 1 0 2 4 8", i, rd_valid, rd_buf, rd_col, rd_rows, rd_words);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    row_valid = 1'b1; valid_input = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    row_valid = 1'b0; rd_ready = 1'b1; step(); step();
    rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || row_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got v=%0b rdy=%0b want 0 1", rd_valid, row_ready); end
    checks++; if (rd_col !== 2'd0 || wr_buf !== 1'b0 || rd_rows !== 3'd0 || rd_words !== 5'd0) begin errors++; $display("FAIL async_reset_state: got col=%0d wbuf=%0b rows=%0d words=%0d want 0 0 0 0", rd_col, wr_buf, rd_rows, rd_words); end
    #3 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush_partial();
    test_flush_edges();
    test_simultaneous();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
